// File: rtl/dvi_link_sequencer_pkg.sv
// Shared definitions for the DVI link sequencer: DVI control tokens and FSM state encodings.
package dvi_link_sequencer_pkg;

  // DVI control tokens, indexed by {c1,c0}
  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  // Encodings are visible on the link_state status port
  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_LOCK_WAIT  = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_FRAME_WAIT = 3'd3,
    ST_RUN        = 3'd4
  } link_state_e;

endpackage

// File: rtl/dvi_link_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dvi_link_sequencer.sv
// Pixel-clock link bring-up sequencer and per-channel 10b word mux for the TMDS serializer.
// States: HOLD -> LOCK_WAIT -> RELEASE -> FRAME_WAIT -> RUN; any lock loss returns to HOLD.
module dvi_link_sequencer
  import dvi_link_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE = 1024,
  parameter int PREAMBLE    = 64,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic       i_clk_pixel,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic [9:0] i_tmds_video0,
  input  logic [9:0] i_tmds_video1,
  input  logic [9:0] i_tmds_video2,
  output logic [9:0] o_tmds_internal0,
  output logic [9:0] o_tmds_internal1,
  output logic [9:0] o_tmds_internal2,
  output logic       o_ser_reset,
  output logic       o_link_up,
  output logic [2:0] o_link_state
);

  localparam int CNT_MAX = (LOCK_STABLE > PREAMBLE) ? LOCK_STABLE : PREAMBLE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST     = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] PREAMBLE_LAST = CNT_W'(PREAMBLE - 1);

  function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    case ({c1, c0})
      2'b00:   tok = CTL_00;
      2'b01:   tok = CTL_01;
      2'b10:   tok = CTL_10;
      default: tok = CTL_11;
    endcase
    return tok;
  endfunction

  logic              w_lock_s;
  logic              w_vsync_act;
  logic              w_frame_start;
  logic              w_run_mux;
  link_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ser_reset;
  logic              r_link_up;
  logic              r_vsync_act_d;
  logic [9:0]        r_tmds0;
  logic [9:0]        r_tmds1;
  logic [9:0]        r_tmds2;

  sync_2ff u_lock_sync (
    .i_clk (i_clk_pixel),
    .i_rst (i_reset),
    .i_d   (i_pll_locked),
    .o_q   (w_lock_s)
  );

  // Track "vsync active" rather than the raw level so the reset value means inactive for either polarity
  assign w_vsync_act   = (i_vsync == VSYNC_POL);
  assign w_frame_start = r_vsync_act_d && !w_vsync_act;

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_vsync_act_d <= 1'b0;
    end else begin
      r_vsync_act_d <= w_vsync_act;
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_ser_reset <= 1'b1;
      r_link_up   <= 1'b0;
    end else if (r_state != ST_HOLD && !w_lock_s) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_ser_reset <= 1'b1;
      r_link_up   <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_lock_s) begin
            r_state <= ST_LOCK_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_LOCK_WAIT: begin
          if (r_cnt == LOCK_LAST) begin
            r_state     <= ST_RELEASE;
            r_cnt       <= '0;
            r_ser_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == PREAMBLE_LAST) begin
            r_state <= ST_FRAME_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FRAME_WAIT: begin
          if (w_frame_start) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_link_up <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ser_reset <= 1'b0;
          r_link_up   <= 1'b1;
        end
        default: begin
          r_state     <= ST_HOLD;
          r_cnt       <= '0;
          r_ser_reset <= 1'b1;
          r_link_up   <= 1'b0;
        end
      endcase
    end
  end

  // Qualify with lock so the words fall back to CTL_00 on the same edge the FSM drops to HOLD
  assign w_run_mux = (r_state == ST_RUN) && w_lock_s;

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_tmds0 <= CTL_00;
      r_tmds1 <= CTL_00;
      r_tmds2 <= CTL_00;
    end else if (w_run_mux && i_de) begin
      r_tmds0 <= i_tmds_video0;
      r_tmds1 <= i_tmds_video1;
      r_tmds2 <= i_tmds_video2;
    end else if (w_run_mux) begin
      r_tmds0 <= ctl_token(i_vsync, i_hsync);
      r_tmds1 <= CTL_00;
      r_tmds2 <= CTL_00;
    end else begin
      r_tmds0 <= CTL_00;
      r_tmds1 <= CTL_00;
      r_tmds2 <= CTL_00;
    end
  end

  assign o_tmds_internal0 = r_tmds0;
  assign o_tmds_internal1 = r_tmds1;
  assign o_tmds_internal2 = r_tmds2;
  assign o_ser_reset      = r_ser_reset;
  assign o_link_up        = r_link_up;
  assign o_link_state     = r_state;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Directed bench for dvi_link_sequencer with LOCK_STABLE=8, PREAMBLE=4, VSYNC_POL=1.
module tb_dvi_link_sequencer;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] video0;
  logic [9:0] video1;
  logic [9:0] video2;
  logic [9:0] ch0;
  logic [9:0] ch1;
  logic [9:0] ch2;
  logic       ser_reset;
  logic       link_up;
  logic [2:0] link_state;

  int total = 0;
  int bad   = 0;

  dvi_link_sequencer #(
    .LOCK_STABLE (8),
    .PREAMBLE    (4),
    .VSYNC_POL   (1'b1)
  ) dut (
    .i_clk_pixel      (clk_pixel),
    .i_reset          (reset),
    .i_pll_locked     (pll_locked),
    .i_hsync          (hsync),
    .i_vsync          (vsync),
    .i_de             (de),
    .i_tmds_video0    (video0),
    .i_tmds_video1    (video1),
    .i_tmds_video2    (video2),
    .o_tmds_internal0 (ch0),
    .o_tmds_internal1 (ch1),
    .o_tmds_internal2 (ch2),
    .o_ser_reset      (ser_reset),
    .o_link_up        (link_up),
    .o_link_state     (link_state)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pixel);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [2:0] st, input logic sr, input logic lu);
    chk({tag, "_state"}, 32'(link_state), 32'(st));
    chk({tag, "_ser_reset"}, 32'(ser_reset), 32'(sr));
    chk({tag, "_link_up"}, 32'(link_up), 32'(lu));
  endtask

  task automatic chk_words(input string tag, input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    chk({tag, "_ch0"}, 32'(ch0), 32'(e0));
    chk({tag, "_ch1"}, 32'(ch1), 32'(e1));
    chk({tag, "_ch2"}, 32'(ch2), 32'(e2));
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    hsync      = 1'b0;
    vsync      = 1'b0;
    de         = 1'b0;
    video0     = 10'h000;
    video1     = 10'h000;
    video2     = 10'h000;
    #2;
    chk_status("rst", 3'd0, 1'b1, 1'b0);
    chk_words("rst", T00, T00, T00);

    // bring-up with lock present from time zero
    tick(1);
    reset = 1'b0;
    tick(2);
    chk_status("pre_lw", 3'd0, 1'b1, 1'b0);
    tick(1);
    chk_status("lw_enter", 3'd1, 1'b1, 1'b0);
    tick(7);
    chk_status("lw_last", 3'd1, 1'b1, 1'b0);
    tick(1);
    chk_status("rel_enter", 3'd2, 1'b0, 1'b0);
    tick(3);
    chk_status("rel_last", 3'd2, 1'b0, 1'b0);
    tick(1);
    chk_status("fw_enter", 3'd3, 1'b0, 1'b0);

    // frame start on vsync falling out of active
    vsync = 1'b1;
    tick(1);
    chk_status("fw_vs_hi", 3'd3, 1'b0, 1'b0);
    vsync = 1'b0;
    tick(1);
    chk_status("run_enter", 3'd4, 1'b0, 1'b1);
    chk_words("run_enter", T00, T00, T00);

    // RUN mux
    de = 1'b1; video0 = 10'h2AB; video1 = 10'h155; video2 = 10'h0F0;
    tick(1);
    chk_words("video", 10'h2AB, 10'h155, 10'h0F0);
    de = 1'b0; vsync = 1'b1; hsync = 1'b0;
    tick(1);
    chk_words("tok10", T10, T00, T00);
    vsync = 1'b0; hsync = 1'b1;
    tick(1);
    chk_words("tok01", T01, T00, T00);
    vsync = 1'b1; hsync = 1'b1;
    tick(1);
    chk_words("tok11", T11, T00, T00);
    vsync = 1'b0; hsync = 1'b0;
    tick(1);
    chk_words("tok00", T00, T00, T00);
    de = 1'b1; vsync = 1'b1; hsync = 1'b1; video0 = 10'h1C7;
    tick(1);
    chk_words("de_wins", 10'h1C7, 10'h155, 10'h0F0);

    // lock loss in RUN: two sync flops then the state edge
    pll_locked = 1'b0;
    tick(2);
    chk_status("drop_t2", 3'd4, 1'b0, 1'b1);
    chk_words("drop_t2", 10'h1C7, 10'h155, 10'h0F0);
    tick(1);
    chk_status("drop_t3", 3'd0, 1'b1, 1'b0);
    chk_words("drop_t3", T00, T00, T00);
    tick(1);
    chk_status("drop_hold", 3'd0, 1'b1, 1'b0);

    // relock replays the whole sequence; vsync held active so FRAME_WAIT persists
    pll_locked = 1'b1;
    tick(2);
    chk_status("relock_t2", 3'd0, 1'b1, 1'b0);
    tick(1);
    chk_status("relock_lw", 3'd1, 1'b1, 1'b0);
    tick(7);
    chk_status("relock_lw_last", 3'd1, 1'b1, 1'b0);
    tick(1);
    chk_status("relock_rel", 3'd2, 1'b0, 1'b0);
    tick(4);
    chk_status("relock_fw", 3'd3, 1'b0, 1'b0);
    chk_words("relock_fw", T00, T00, T00);

    // lock loss from FRAME_WAIT
    pll_locked = 1'b0;
    tick(3);
    chk_status("fw_drop", 3'd0, 1'b1, 1'b0);

    // one-cycle glitch while LOCK_WAIT count is 5
    pll_locked = 1'b1;
    tick(3);
    chk_status("gl_lw", 3'd1, 1'b1, 1'b0);
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk_status("gl_t10", 3'd1, 1'b1, 1'b0);
    tick(1);
    chk_status("gl_hold", 3'd0, 1'b1, 1'b0);
    tick(1);
    chk_status("gl_lw_again", 3'd1, 1'b1, 1'b0);
    tick(7);
    chk_status("gl_no_early", 3'd1, 1'b1, 1'b0);
    tick(1);
    chk_status("gl_rel", 3'd2, 1'b0, 1'b0);
    tick(4);
    chk_status("gl_fw", 3'd3, 1'b0, 1'b0);

    // back to RUN, then async reset mid-cycle
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0; de = 1'b1; video0 = 10'h2AB;
    tick(1);
    chk_status("run2", 3'd4, 1'b0, 1'b1);
    tick(1);
    chk_words("run2_video", 10'h2AB, 10'h155, 10'h0F0);
    #2;
    reset = 1'b1;
    #1;
    chk_status("async_rst", 3'd0, 1'b1, 1'b0);
    chk_words("async_rst", T00, T00, T00);
    tick(1);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
